// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - MIPS execute-stage ALU, ALU-control decoder, aux adder, sticky overflow.
// Define ALU_SHIFT_EN to build the barrel shifter and LUI; otherwise those codes yield zero.
module alu_exec_unit #(
    parameter int ADDER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [3:0]         alu_op,
    input  logic [5:0]         funct,
    input  logic [31:0]        operand_a,
    input  logic [31:0]        operand_b,
    input  logic [4:0]         shamt,
    output logic [3:0]         alu_ctrl,
    output logic [31:0]        alu_result,
    output logic               zero,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic               ovf_sticky,
    input  logic [ADDER_W-1:0] add_a,
    input  logic [ADDER_W-1:0] add_b,
    output logic [ADDER_W-1:0] add_sum
);

    localparam logic [3:0] CtlAnd  = 4'b0000;
    localparam logic [3:0] CtlOr   = 4'b0001;
    localparam logic [3:0] CtlAdd  = 4'b0010;
    localparam logic [3:0] CtlXor  = 4'b0011;
    localparam logic [3:0] CtlAddu = 4'b0100;
    localparam logic [3:0] CtlSubu = 4'b0101;
    localparam logic [3:0] CtlSub  = 4'b0110;
    localparam logic [3:0] CtlSlt  = 4'b0111;
    localparam logic [3:0] CtlSll  = 4'b1000;
    localparam logic [3:0] CtlSrl  = 4'b1001;
    localparam logic [3:0] CtlSra  = 4'b1010;
    localparam logic [3:0] CtlSltu = 4'b1011;
    localparam logic [3:0] CtlNor  = 4'b1100;
    localparam logic [3:0] CtlLui  = 4'b1101;
    localparam logic [3:0] CtlPass = 4'b1110;

    logic [3:0]  functCtrl;
    logic        varShift;
    logic [31:0] sumAB;
    logic [31:0] diffAB;
    logic [31:0] rawResult;
    logic        rawOvf;
    logic        shiftOvf;

    always_comb begin
        functCtrl = CtlAdd;
        unique case (funct)
            6'b100000: functCtrl = CtlAdd;
            6'b100001: functCtrl = CtlAddu;
            6'b100010: functCtrl = CtlSub;
            6'b100011: functCtrl = CtlSubu;
            6'b100100: functCtrl = CtlAnd;
            6'b100101: functCtrl = CtlOr;
            6'b100110: functCtrl = CtlXor;
            6'b100111: functCtrl = CtlNor;
            6'b101010: functCtrl = CtlSlt;
            6'b101011: functCtrl = CtlSltu;
            6'b000000, 6'b000100: functCtrl = CtlSll;
            6'b000010, 6'b000110: functCtrl = CtlSrl;
            6'b000011, 6'b000111: functCtrl = CtlSra;
            default:   functCtrl = CtlAdd;
        endcase
    end

    always_comb begin
        alu_ctrl = CtlAdd;
        unique case (alu_op)
            4'b0000: alu_ctrl = CtlAdd;
            4'b0001: alu_ctrl = CtlSub;
            4'b0010: alu_ctrl = functCtrl;
            4'b0011: alu_ctrl = CtlAnd;
            4'b0100: alu_ctrl = CtlOr;
            4'b0101: alu_ctrl = CtlSlt;
            4'b0110: alu_ctrl = CtlLui;
            4'b0111: alu_ctrl = CtlXor;
            4'b1000: alu_ctrl = CtlAddu;
            4'b1001: alu_ctrl = CtlSltu;
            default: alu_ctrl = CtlAdd;
        endcase
    end

    // Variable shifts share codes with constant shifts; only the amount source differs.
    assign varShift = (alu_op == 4'b0010) &&
                      (funct == 6'b000100 || funct == 6'b000110 || funct == 6'b000111);

    assign sumAB  = operand_a + operand_b;
    assign diffAB = operand_a - operand_b;

`ifdef ALU_SHIFT_EN
    logic [4:0]  shiftAmt;
    logic [31:0] sllRes;
    logic [31:0] srlRes;
    logic [31:0] sraRes;
    logic [31:0] luiRes;

    assign shiftAmt = varShift ? operand_a[4:0] : shamt;
    assign sllRes   = operand_b << shiftAmt;
    assign srlRes   = operand_b >> shiftAmt;
    assign sraRes   = $unsigned($signed(operand_b) >>> shiftAmt);
    assign luiRes   = {operand_b[15:0], 16'h0000};
    assign shiftOvf = 1'b0;
`else
    logic [31:0] sllRes;
    logic [31:0] srlRes;
    logic [31:0] sraRes;
    logic [31:0] luiRes;
    logic        unusedShiftInputs;

    assign sllRes   = 32'h0;
    assign srlRes   = 32'h0;
    assign sraRes   = 32'h0;
    assign luiRes   = 32'h0;
    assign shiftOvf = 1'b0;
    assign unusedShiftInputs = ^{shamt, varShift};
`endif

    always_comb begin
        rawResult = 32'h0;
        rawOvf    = 1'b0;
        unique case (alu_ctrl)
            CtlAnd:  rawResult = operand_a & operand_b;
            CtlOr:   rawResult = operand_a | operand_b;
            CtlAdd: begin
                rawResult = sumAB;
                rawOvf    = (operand_a[31] == operand_b[31]) && (sumAB[31] != operand_a[31]);
            end
            CtlXor:  rawResult = operand_a ^ operand_b;
            CtlAddu: rawResult = sumAB;
            CtlSubu: rawResult = diffAB;
            CtlSub: begin
                rawResult = diffAB;
                rawOvf    = (operand_a[31] != operand_b[31]) && (diffAB[31] != operand_a[31]);
            end
            CtlSlt:  rawResult = {31'h0, $signed(operand_a) < $signed(operand_b)};
            CtlSll:  begin rawResult = sllRes; rawOvf = shiftOvf; end
            CtlSrl:  begin rawResult = srlRes; rawOvf = shiftOvf; end
            CtlSra:  begin rawResult = sraRes; rawOvf = shiftOvf; end
            CtlSltu: rawResult = {31'h0, operand_a < operand_b};
            CtlNor:  rawResult = ~(operand_a | operand_b);
            CtlLui:  rawResult = luiRes;
            CtlPass: rawResult = operand_b;
            default: rawResult = 32'h0;
        endcase
    end

    // Reset forces the result and flags low asynchronously; decode and aux adder keep running.
    assign alu_result = reset ? 32'h0 : rawResult;
    assign zero       = !reset && (rawResult == 32'h0);
    assign overflow   = !reset && rawOvf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_sticky <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end else if (overflow) begin
            ovf_sticky <= 1'b1;
        end
    end

    assign add_sum = add_a + add_b;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - directed self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;

    logic        clk;
    logic        reset;
    logic [3:0]  alu_op;
    logic [5:0]  funct;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic [4:0]  shamt;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic        zero;
    logic        overflow;
    logic        ovf_clr;
    logic        ovf_sticky;
    logic [31:0] add_a;
    logic [31:0] add_b;
    logic [31:0] add_sum;

    int checks;
    int failures;

    alu_exec_unit #(.ADDER_W(32)) dut (
        .clk(clk),
        .reset(reset),
        .alu_op(alu_op),
        .funct(funct),
        .operand_a(operand_a),
        .operand_b(operand_b),
        .shamt(shamt),
        .alu_ctrl(alu_ctrl),
        .alu_result(alu_result),
        .zero(zero),
        .overflow(overflow),
        .ovf_clr(ovf_clr),
        .ovf_sticky(ovf_sticky),
        .add_a(add_a),
        .add_b(add_b),
        .add_sum(add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [5:0] fn, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        alu_op    = op;
        funct     = fn;
        operand_a = a;
        operand_b = b;
        shamt     = sh;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        ovf_clr  = 1'b0;
        add_a    = 32'h0040_0000;
        add_b    = 32'h4;

        // 1: reset gating, then ADD
        drive(4'b0000, 6'b000000, 32'd5, 32'd7, 5'd0);
        check("rst_result", alu_result, 32'h0);
        check("rst_zero", {31'h0, zero}, 32'h0);
        check("rst_sticky", {31'h0, ovf_sticky}, 32'h0);
        check("rst_ctrl", {28'h0, alu_ctrl}, 32'h2);
        tick();
        reset = 1'b0;
        #1;
        check("add_result", alu_result, 32'd12);
        check("add_ctrl", {28'h0, alu_ctrl}, 32'h2);
        check("add_zero", {31'h0, zero}, 32'h0);

        // 2: R-type SUB / SLT / SLTU
        drive(4'b0010, 6'b100010, 32'd9, 32'd9, 5'd0);
        check("sub_ctrl", {28'h0, alu_ctrl}, 32'h6);
        check("sub_result", alu_result, 32'h0);
        check("sub_zero", {31'h0, zero}, 32'h1);
        drive(4'b0010, 6'b101010, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("slt_ctrl", {28'h0, alu_ctrl}, 32'h7);
        check("slt_result", alu_result, 32'h1);
        drive(4'b0010, 6'b101011, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check("sltu_ctrl", {28'h0, alu_ctrl}, 32'hB);
        check("sltu_result", alu_result, 32'h0);
        check("sltu_zero", {31'h0, zero}, 32'h1);

        // 3: overflow and sticky register
        drive(4'b0000, 6'b000000, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("ovf_add_result", alu_result, 32'h8000_0000);
        check("ovf_add_flag", {31'h0, overflow}, 32'h1);
        check("sticky_before_edge", {31'h0, ovf_sticky}, 32'h0);
        tick();
        check("sticky_set", {31'h0, ovf_sticky}, 32'h1);
        drive(4'b1000, 6'b000000, 32'h7FFF_FFFF, 32'd1, 5'd0);
        check("addu_ctrl", {28'h0, alu_ctrl}, 32'h4);
        check("addu_result", alu_result, 32'h8000_0000);
        check("addu_ovf", {31'h0, overflow}, 32'h0);
        tick();
        check("sticky_hold", {31'h0, ovf_sticky}, 32'h1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("sticky_clr", {31'h0, ovf_sticky}, 32'h0);
        drive(4'b0001, 6'b000000, 32'h8000_0000, 32'd1, 5'd0);
        check("ovf_sub_result", alu_result, 32'h7FFF_FFFF);
        check("ovf_sub_flag", {31'h0, overflow}, 32'h1);
        ovf_clr = 1'b1;
        tick();
        check("sticky_clr_priority", {31'h0, ovf_sticky}, 32'h0);
        ovf_clr = 1'b0;
        tick();
        check("sticky_sub_set", {31'h0, ovf_sticky}, 32'h1);
        drive(4'b0010, 6'b100011, 32'h8000_0000, 32'd1, 5'd0);
        check("subu_ovf", {31'h0, overflow}, 32'h0);
        check("subu_result", alu_result, 32'h7FFF_FFFF);
        drive(4'b0000, 6'b000000, 32'h7FFF_FFFF, 32'd1, 5'd0);
        reset = 1'b1;
        #1;
        check("rst_async_sticky", {31'h0, ovf_sticky}, 32'h0);
        check("rst_ovf", {31'h0, overflow}, 32'h0);
        reset = 1'b0;
        #1;

        // 4: shifts
        drive(4'b0010, 6'b000000, 32'h0, 32'h0000_000F, 5'd4);
        check("sll_ctrl", {28'h0, alu_ctrl}, 32'h8);
`ifdef ALU_SHIFT_EN
        check("sll_result", alu_result, 32'h0000_00F0);
`else
        check("sll_result", alu_result, 32'h0);
`endif
        drive(4'b0010, 6'b000011, 32'h0, 32'h8000_0000, 5'd4);
        check("sra_ctrl", {28'h0, alu_ctrl}, 32'hA);
`ifdef ALU_SHIFT_EN
        check("sra_result", alu_result, 32'hF800_0000);
`else
        check("sra_result", alu_result, 32'h0);
`endif
        drive(4'b0010, 6'b000110, 32'd8, 32'h0000_0100, 5'd0);
        check("srlv_ctrl", {28'h0, alu_ctrl}, 32'h9);
        check("shift_ovf", {31'h0, overflow}, 32'h0);
`ifdef ALU_SHIFT_EN
        check("srlv_result", alu_result, 32'h1);
`else
        check("srlv_result", alu_result, 32'h0);
`endif

        // 5: LUI and logic ops
        drive(4'b0110, 6'b000000, 32'h0, 32'h0000_1234, 5'd0);
        check("lui_ctrl", {28'h0, alu_ctrl}, 32'hD);
`ifdef ALU_SHIFT_EN
        check("lui_result", alu_result, 32'h1234_0000);
`else
        check("lui_result", alu_result, 32'h0);
`endif
        drive(4'b0011, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("and_ctrl", {28'h0, alu_ctrl}, 32'h0);
        check("and_result", alu_result, 32'hF000_F000);
        drive(4'b0100, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("or_result", alu_result, 32'hFFF0_FFF0);
        drive(4'b0111, 6'b000000, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("xor_result", alu_result, 32'h0FF0_0FF0);
        drive(4'b0010, 6'b100111, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0);
        check("nor_ctrl", {28'h0, alu_ctrl}, 32'hC);
        check("nor_result", alu_result, 32'h000F_000F);
        drive(4'b0101, 6'b000000, 32'h8000_0000, 32'h0000_0001, 5'd0);
        check("slt_op_result", alu_result, 32'h1);
        drive(4'b1001, 6'b000000, 32'h0000_0001, 32'h8000_0000, 5'd0);
        check("sltu_op_result", alu_result, 32'h1);
        drive(4'b1111, 6'b000000, 32'd3, 32'd4, 5'd0);
        check("default_op_ctrl", {28'h0, alu_ctrl}, 32'h2);
        check("default_op_result", alu_result, 32'd7);
        drive(4'b0010, 6'b111111, 32'd3, 32'd4, 5'd0);
        check("default_funct_ctrl", {28'h0, alu_ctrl}, 32'h2);

        // 6: auxiliary adder, unaffected by reset
        add_a = 32'h0040_0000;
        add_b = 32'h4;
        #1;
        check("adder_pc4", add_sum, 32'h0040_0004);
        add_a = 32'hFFFF_FFFC;
        add_b = 32'h8;
        #1;
        check("adder_wrap", add_sum, 32'h0000_0004);
        reset = 1'b1;
        #1;
        check("adder_in_reset", add_sum, 32'h0000_0004);
        reset = 1'b0;
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage arithmetic block of the 5-stage MIPS pipeline. It contains three parts:
- ALU-control decoder: maps the 4-bit pipeline ALUOp plus the 6-bit funct field to a 4-bit ALU operation code.
- 32-bit ALU: produces the result, zero and overflow.
- Auxiliary 32-bit adder: used for PC+4 and branch-target computation.

The datapath is combinational. A sticky overflow status register is the only clocked state.

Parameters:
ADDER_W, 32, width of the auxiliary adder operands and sum (ALU datapath fixed at 32)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
alu_op  input  4  ALUOp from ID/EX register
funct  input  6  instruction bits [5:0] (sign-extended immediate low bits)
operand_a  input  32  ALU source A (rs, forwarded)
operand_b  input  32  ALU source B (rt or immediate)
shamt  input  5  constant shift amount
alu_ctrl  output  4  decoded ALU operation code
alu_result  output  32  ALU result
zero  output  1  alu_result == 0
overflow  output  1  signed overflow of ADD/SUB
ovf_clr  input  1  synchronous clear of ovf_sticky
ovf_sticky  output  1  latched overflow status
add_a  input  ADDER_W  adder operand A
add_b  input  ADDER_W  adder operand B
add_sum  output  ADDER_W  add_a + add_b

Behaviour:
ALUOp decode (alu_op -> alu_ctrl):
- 0000 -> ADD
- 0001 -> SUB
- 0010 -> R-type, decoded from funct
- 0011 -> AND
- 0100 -> OR
- 0101 -> SLT
- 0110 -> LUI
- 0111 -> XOR
- 1000 -> ADDU
- 1001 -> SLTU
- any other -> ADD

R-type funct decode:
- 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
- 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
- 101010 SLT, 101011 SLTU
- 000000 SLL, 000010 SRL, 000011 SRA
- 000100 SLLV, 000110 SRLV, 000111 SRAV (same codes as SLL/SRL/SRA, but shift amount = operand_a[4:0])
- any other funct -> ADD

alu_ctrl codes and results (b = operand_b):
- 0000 AND: a & b
- 0001 OR: a | b
- 0010 ADD: a + b
- 0011 XOR: a ^ b
- 0100 ADDU: a + b
- 0101 SUBU: a - b
- 0110 SUB: a - b
- 0111 SLT: signed a < b ? 1 : 0
- 1000 SLL: b << amt
- 1001 SRL: b >> amt (logical)
- 1010 SRA: b >>> amt (arithmetic)
- 1011 SLTU: unsigned compare, 1 or 0
- 1100 NOR: ~(a | b)
- 1101 LUI: {b[15:0], 16'h0}
- 1110 PASS_B: b
- 1111: result 0

Arithmetic and flag rules:
- amt = shamt for constant shifts; operand_a[4:0] for variable shifts.
- All arithmetic wraps modulo 2^32.
- overflow = 1 only for ADD/SUB when signed overflow occurs; ADDU/SUBU and all other ops give 0.
- The result is still written on overflow (no trap).
- zero = (alu_result == 0), combinational.

Reset:
- While reset = 1: alu_result = 0, zero = 0, overflow = 0, ovf_sticky = 0 (asynchronous).
- alu_ctrl and add_sum are unaffected by reset.

Sticky overflow register:
- At each rising edge: ovf_clr = 1 -> clear to 0 (clear has priority); else if overflow = 1 -> set to 1; else hold.
- If overflow and ovf_clr are both high on the same edge, the register clears.

Auxiliary adder: add_sum = add_a + add_b, combinational, carry-out discarded.

Latency:
- All outputs except ovf_sticky are combinational, zero cycles.
- ovf_sticky has one cycle of latency.

Optional Feature:
Macro: ALU_SHIFT_EN.
- Defined: SLL/SRL/SRA (constant and variable) and LUI are implemented as above.
- Undefined: the barrel shifter is omitted; codes 1000, 1001, 1010 and 1101 yield alu_result = 0 with overflow = 0. Decode is unchanged.

Test Plan:
1. reset = 1 with a = 5, b = 7, alu_op = 0000 -> alu_result = 0, zero = 0, ovf_sticky = 0. Release reset -> alu_result = 12, alu_ctrl = 0010.
2. alu_op = 0010, funct = 100010, a = 9, b = 9 -> alu_ctrl = 0110, alu_result = 0, zero = 1. Same with funct = 101010, a = 0xFFFFFFFF, b = 1 -> result 1; funct = 101011 -> result 0.
3. ADD with a = 0x7FFFFFFF, b = 1 -> result 0x80000000, overflow = 1; ovf_sticky = 1 after next edge. ADDU with same operands -> overflow = 0. Pulse ovf_clr -> ovf_sticky = 0.
4. Shifts (ALU_SHIFT_EN defined):
   - funct = 000000, shamt = 4, b = 0x0000000F -> 0x000000F0.
   - funct = 000011, shamt = 4, b = 0x80000000 -> 0xF8000000.
   - funct = 000110, a = 8, b = 0x100 -> 0x1.
   - Without the macro: all three -> 0.
5. alu_op = 0110, b = 0x00001234 -> alu_result = 0x12340000. alu_op = 0011, a = 0xF0F0F0F0, b = 0xFF00FF00 -> 0xF000F000.
6. Adder: add_a = 0x00400000, add_b = 4 -> 0x00400004. add_a = 0xFFFFFFFC, add_b = 8 -> 0x00000004 (wrap). Reset asserted does not alter add_sum.
